inc_reg_bank: RTL and testbench

//  Bank of seven counter registers: ROW, COL, CURR, STA, STB, STC, R1.

---
 rtl/inc_bank_pkg.sv | 21 ++
 rtl/inc_reg_bank_if.sv | 49 ++++
 rtl/inc_cell.sv | 77 +++++++
 rtl/inc_reg_bank.sv | 72 +++++++
 tb/tb_inc_reg_bank.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/inc_bank_pkg.sv
// -----------------------------------------------------------------------------
// inc_bank_pkg
// Shared constants for the increment register bank and its control unit.
// The REG_* indices are the bit positions of the increment strobes and the
// values of the write-select field. REG_NONE selects no register.
// -----------------------------------------------------------------------------
package inc_bank_pkg;

  localparam int unsigned NUM_INC_REGS = 7;
  localparam int unsigned SEL_W        = 3;

  localparam logic [SEL_W-1:0] REG_ROW  = 3'd0;
  localparam logic [SEL_W-1:0] REG_COL  = 3'd1;
  localparam logic [SEL_W-1:0] REG_CURR = 3'd2;
  localparam logic [SEL_W-1:0] REG_STA  = 3'd3;
  localparam logic [SEL_W-1:0] REG_STB  = 3'd4;
  localparam logic [SEL_W-1:0] REG_STC  = 3'd5;
  localparam logic [SEL_W-1:0] REG_R1   = 3'd6;
  localparam logic [SEL_W-1:0] REG_NONE = 3'd7;

endpackage : inc_bank_pkg

// File: rtl/inc_reg_bank_if.sv
// -----------------------------------------------------------------------------
// inc_reg_bank_if
// Bus between the control side (increment decoder plus control unit) and the
// increment register bank.
//   inc_row..inc_r1 : increment strobes, one per register
//   wr_en/wr_sel/wr_data : single write port, wr_sel = REG_* index
//   row_q..r1_q     : registered counter values
//   wrap            : sticky wrap flags, bit i = register i (zero unless the
//                     bank is built with INC_BANK_WRAP_FLAG_EN)
// Modports: master = control side, slave = register bank.
// -----------------------------------------------------------------------------
interface inc_reg_bank_if
  import inc_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic                    inc_row;
  logic                    inc_col;
  logic                    inc_curr;
  logic                    inc_sta;
  logic                    inc_stb;
  logic                    inc_stc;
  logic                    inc_r1;
  logic                    wr_en;
  logic [SEL_W-1:0]        wr_sel;
  logic [WIDTH-1:0]        wr_data;
  logic [WIDTH-1:0]        row_q;
  logic [WIDTH-1:0]        col_q;
  logic [WIDTH-1:0]        curr_q;
  logic [WIDTH-1:0]        sta_q;
  logic [WIDTH-1:0]        stb_q;
  logic [WIDTH-1:0]        stc_q;
  logic [WIDTH-1:0]        r1_q;
  logic [NUM_INC_REGS-1:0] wrap;

  modport master (
    output inc_row, inc_col, inc_curr, inc_sta, inc_stb, inc_stc, inc_r1,
    output wr_en, wr_sel, wr_data,
    input  row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q, wrap
  );

  modport slave (
    input  inc_row, inc_col, inc_curr, inc_sta, inc_stb, inc_stc, inc_r1,
    input  wr_en, wr_sel, wr_data,
    output row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q, wrap
  );

endinterface : inc_reg_bank_if

// File: rtl/inc_cell.sv
// -----------------------------------------------------------------------------
// inc_cell
// One WIDTH-bit counter register. Load beats increment; increment wraps
// modulo 2^WIDTH. Optional sticky wrap flag when INC_BANK_WRAP_FLAG_EN is
// defined (otherwise wrap_o is constant 0 and no flag flop exists).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ld_i         : load ld_data_i this cycle (highest priority)
//   ld_data_i    : load value
//   inc_i        : increment this cycle
//   val_o        : registered value
//   wrap_o       : sticky wrap flag
// -----------------------------------------------------------------------------
module inc_cell #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] val_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] val_d, val_q;

  always_comb begin
    val_d = val_q;
    if (ld_i) begin
      val_d = ld_data_i;
    end else if (inc_i) begin
      val_d = val_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, whatever the process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

`ifdef INC_BANK_WRAP_FLAG_EN
  logic wrap_d, wrap_q;

  // A write clears the flag even when it coincides with a wrapping increment,
  // because the increment is dropped in that cycle.
  always_comb begin
    wrap_d = wrap_q;
    if (ld_i) begin
      wrap_d = 1'b0;
    end else if (inc_i && (val_q == {WIDTH{1'b1}})) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;
`else
  assign wrap_o = 1'b0;
`endif

endmodule : inc_cell

// File: rtl/inc_reg_bank.sv
// -----------------------------------------------------------------------------
// inc_reg_bank
// Seven counter registers (ROW, COL, CURR, STA, STB, STC, R1) fed by the
// increment decoder strobes and one datapath write port. The top decodes
// wr_sel into per-register load enables and fans the cells out to the bus.
// Optional feature macro: INC_BANK_WRAP_FLAG_EN (sticky per-register wrap
// flags on bus.wrap; tied to zero when undefined).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, all registers to RST_VAL
//   bus   : inc_reg_bank_if slave (strobes, write port, register outputs)
// All outputs are registered; latency from strobe or write is one cycle.
// -----------------------------------------------------------------------------
module inc_reg_bank
  import inc_bank_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  inc_reg_bank_if.slave  bus
);

  logic [NUM_INC_REGS-1:0] inc_vec;
  logic [NUM_INC_REGS-1:0] ld_vec;
  logic [NUM_INC_REGS-1:0] wrap_vec;
  logic [WIDTH-1:0]        val_vec [NUM_INC_REGS];

  assign inc_vec[REG_ROW]  = bus.inc_row;
  assign inc_vec[REG_COL]  = bus.inc_col;
  assign inc_vec[REG_CURR] = bus.inc_curr;
  assign inc_vec[REG_STA]  = bus.inc_sta;
  assign inc_vec[REG_STB]  = bus.inc_stb;
  assign inc_vec[REG_STC]  = bus.inc_stc;
  assign inc_vec[REG_R1]   = bus.inc_r1;

  // REG_NONE never matches an index below NUM_INC_REGS, so it loads nothing.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring latches on any path that skips an assignment.
  always_comb begin
    ld_vec = '0;
    for (int i = 0; i < NUM_INC_REGS; i++) begin
      ld_vec[i] = bus.wr_en && (bus.wr_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_INC_REGS; g++) begin : g_cell
    inc_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_i      (ld_vec[g]),
      .ld_data_i (bus.wr_data),
      .inc_i     (inc_vec[g]),
      .val_o     (val_vec[g]),
      .wrap_o    (wrap_vec[g])
    );
  end

  assign bus.row_q  = val_vec[REG_ROW];
  assign bus.col_q  = val_vec[REG_COL];
  assign bus.curr_q = val_vec[REG_CURR];
  assign bus.sta_q  = val_vec[REG_STA];
  assign bus.stb_q  = val_vec[REG_STB];
  assign bus.stc_q  = val_vec[REG_STC];
  assign bus.r1_q   = val_vec[REG_R1];
  assign bus.wrap   = wrap_vec;

endmodule : inc_reg_bank

// File: tb/tb_inc_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_inc_reg_bank
// Self-checking bench for inc_reg_bank. A behavioural model computes the
// expected register state for every driven cycle and pushes it onto a
// scoreboard queue; one cycle later the entry is popped and compared with
// the DUT outputs. Compile with +define+INC_BANK_WRAP_FLAG_EN to exercise the
// wrap flags; otherwise wrap is expected to stay zero.
// -----------------------------------------------------------------------------
module tb_inc_reg_bank;
  import inc_bank_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [NUM_INC_REGS-1:0][W-1:0] v;
    logic [NUM_INC_REGS-1:0]        w;
  } exp_t;

  logic clk;
  logic rst_n;

  inc_reg_bank_if #(.WIDTH(W)) bus ();

  inc_reg_bank #(
    .WIDTH   (W),
    .RST_VAL (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t model;
  exp_t sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] obs_val(input int i);
    case (i)
      0:       return bus.row_q;
      1:       return bus.col_q;
      2:       return bus.curr_q;
      3:       return bus.sta_q;
      4:       return bus.stb_q;
      5:       return bus.stc_q;
      default: return bus.r1_q;
    endcase
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    for (int i = 0; i < NUM_INC_REGS; i++) begin
      check($sformatf("%s.reg%0d", tag, i), 32'(obs_val(i)), 32'(e.v[i]));
    end
    check($sformatf("%s.wrap", tag), 32'(bus.wrap), 32'(e.w));
  endtask

  function automatic exp_t reset_state();
    exp_t e;
    e.v = '0;
    e.w = '0;
    return e;
  endfunction

  // Drive one cycle of stimulus, predict the next state, compare after the edge.
  task automatic apply(input string tag, input logic [6:0] inc,
                       input logic we, input logic [2:0] sel, input logic [W-1:0] data);
    exp_t e;
    bus.inc_row  = inc[REG_ROW];
    bus.inc_col  = inc[REG_COL];
    bus.inc_curr = inc[REG_CURR];
    bus.inc_sta  = inc[REG_STA];
    bus.inc_stb  = inc[REG_STB];
    bus.inc_stc  = inc[REG_STC];
    bus.inc_r1   = inc[REG_R1];
    bus.wr_en    = we;
    bus.wr_sel   = sel;
    bus.wr_data  = data;
    for (int i = 0; i < NUM_INC_REGS; i++) begin
      if (we && (sel == 3'(i))) begin
        model.v[i] = data;
        model.w[i] = 1'b0;
      end else if (inc[i]) begin
`ifdef INC_BANK_WRAP_FLAG_EN
        if (model.v[i] == 8'hFF) model.w[i] = 1'b1;
`endif
        model.v[i] = model.v[i] + 8'h01;
      end
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      compare_all(tag, e);
    end
  endtask

  task automatic idle(input string tag);
    apply(tag, 7'b0, 1'b0, REG_NONE, 8'h00);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model = reset_state();
    compare_all(tag, model);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.inc_row  = 1'b0;
    bus.inc_col  = 1'b0;
    bus.inc_curr = 1'b0;
    bus.inc_sta  = 1'b0;
    bus.inc_stb  = 1'b0;
    bus.inc_stc  = 1'b0;
    bus.inc_r1   = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_sel   = REG_NONE;
    bus.wr_data  = 8'h00;
    model        = reset_state();
    #12;
    compare_all("por", model);
    @(negedge clk);
    rst_n = 1'b1;

    // COL counts 1, 2, 3 while its strobe is held; others stay 0.
    for (int k = 0; k < 3; k++) apply($sformatf("col%0d", k), 7'b000_0010, 1'b0, REG_NONE, 8'h00);

    // Write beats a simultaneous increment on STA.
    apply("sta_wr_inc", 7'b000_1000, 1'b1, REG_STA, 8'h40);
    check("sta_is_40", 32'(bus.sta_q), 32'h40);

    // R1 wraps from all-ones; wrap[6] sets (with the flag) and persists.
    apply("r1_ld_ff", 7'b0, 1'b1, REG_R1, 8'hFF);
    apply("r1_wrap", 7'b100_0000, 1'b0, REG_NONE, 8'h00);
    check("r1_is_00", 32'(bus.r1_q), 32'h00);

    // Count ROW up to 5, then reset mid-count.
    for (int k = 0; k < 5; k++) apply($sformatf("row%0d", k), 7'b000_0001, 1'b0, REG_NONE, 8'h00);
    check("row_is_5", 32'(bus.row_q), 32'h05);
    mid_reset("rst_mid");

    // All strobes at once from 0, then a write to REG_NONE changes nothing.
    apply("all_inc", 7'b111_1111, 1'b0, REG_NONE, 8'h00);
    apply("wr_none", 7'b0, 1'b1, REG_NONE, 8'hAA);

    // Load CURR while STB increments; no cross-effect.
    apply("curr_ld_stb", 7'b001_0000, 1'b1, REG_CURR, 8'h10);

    // Wrap flag lifetime: set, survive idle and a foreign write, cleared by R1 write.
    apply("r1_ld_ff2", 7'b0, 1'b1, REG_R1, 8'hFF);
    apply("r1_wrap2", 7'b100_0000, 1'b0, REG_NONE, 8'h00);
    idle("hold_a");
    apply("wr_row", 7'b0, 1'b1, REG_ROW, 8'h22);
    apply("wr_r1_clr", 7'b0, 1'b1, REG_R1, 8'h03);

    // Write and wrapping increment together: write wins, flag stays clear.
    apply("stc_ld_ff", 7'b0, 1'b1, REG_STC, 8'hFF);
    apply("stc_wr_vs_wrap", 7'b010_0000, 1'b1, REG_STC, 8'h55);
    apply("stc_inc", 7'b010_0000, 1'b0, REG_NONE, 8'h00);

    // Random strobe/write mix against the model.
    for (int k = 0; k < 40; k++) begin
      apply($sformatf("rnd%0d", k), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    mid_reset("rst_end");
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_inc_reg_bank
